// File: rtl/sram_arbiter.sv
// Two-master arbiter in front of sram_ctrl: one requester at a time drives the strobe/wait bus.
// Grants alternate at completion boundaries; mX_lock extends a grant across back-to-back transactions.
module sram_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     m0_addr,
  input  logic [DATA_W-1:0]     m0_wrdata,
  input  logic [DATA_W/8-1:0]   m0_bytesel,
  input  logic                  m0_wren,
  input  logic                  m0_strobe,
  input  logic                  m0_lock,
  output logic                  m0_wait,
  output logic [DATA_W-1:0]     m0_rddata,
  input  logic [ADDR_W-1:0]     m1_addr,
  input  logic [DATA_W-1:0]     m1_wrdata,
  input  logic [DATA_W/8-1:0]   m1_bytesel,
  input  logic                  m1_wren,
  input  logic                  m1_strobe,
  input  logic                  m1_lock,
  output logic                  m1_wait,
  output logic [DATA_W-1:0]     m1_rddata,
  output logic [ADDR_W-1:0]     s_addr,
  output logic [DATA_W-1:0]     s_wrdata,
  output logic [DATA_W/8-1:0]   s_bytesel,
  output logic                  s_wren,
  output logic                  s_strobe,
  input  logic                  s_wait,
  input  logic [DATA_W-1:0]     s_rddata,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Hand-over happens only when the owner has nothing in flight or has just
  // completed without lock while the other master is waiting.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_strobe && m1_strobe) state_d = last_q ? G0 : G1;
        else if (m0_strobe)         state_d = G0;
        else if (m1_strobe)         state_d = G1;
      end
      G0: begin
        if (!m0_strobe) begin
          last_d  = 1'b0;
          state_d = m1_strobe ? G1 : IDLE;
        end else if (!s_wait && !m0_lock && m1_strobe) begin
          last_d  = 1'b0;
          state_d = G1;
        end
      end
      G1: begin
        if (!m1_strobe) begin
          last_d  = 1'b1;
          state_d = m0_strobe ? G0 : IDLE;
        end else if (!s_wait && !m1_lock && m0_strobe) begin
          last_d  = 1'b1;
          state_d = G0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A stalled requester sees wait=1 only while it is actually strobing.
  always_comb begin
    s_addr    = '0;
    s_wrdata  = '0;
    s_bytesel = '0;
    s_wren    = 1'b0;
    s_strobe  = 1'b0;
    m0_wait   = m0_strobe;
    m1_wait   = m1_strobe;
    grant     = 2'b00;
    case (state_q)
      G0: begin
        s_addr    = m0_addr;
        s_wrdata  = m0_wrdata;
        s_bytesel = m0_bytesel;
        s_wren    = m0_wren;
        s_strobe  = m0_strobe;
        m0_wait   = s_wait;
        grant     = 2'b01;
      end
      G1: begin
        s_addr    = m1_addr;
        s_wrdata  = m1_wrdata;
        s_bytesel = m1_bytesel;
        s_wren    = m1_wren;
        s_strobe  = m1_strobe;
        m1_wait   = s_wait;
        grant     = 2'b10;
      end
      default: ;
    endcase
  end

  assign m0_rddata = s_rddata;
  assign m1_rddata = s_rddata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized two-master traffic,
// with a slave memory model and a per-master expected-transaction scoreboard.
module tb_sram_arbiter;

  typedef struct {
    logic [16:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        wr;
    logic        lk;
  } txn_t;

  logic              clk;
  logic              reset_n;
  logic [1:0][16:0]  maddr;
  logic [1:0][31:0]  mwd;
  logic [1:0][3:0]   mbe;
  logic [1:0]        mwr, mstb, mlock;
  wire  [1:0]        mwait;
  wire  [1:0][31:0]  mrd;
  wire  [16:0]       s_addr;
  wire  [31:0]       s_wrdata;
  wire  [3:0]        s_bytesel;
  wire               s_wren, s_strobe;
  logic              s_wait;
  logic [31:0]       s_rddata;
  wire  [1:0]        gnt;

  sram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(maddr[0]), .m0_wrdata(mwd[0]), .m0_bytesel(mbe[0]), .m0_wren(mwr[0]),
    .m0_strobe(mstb[0]), .m0_lock(mlock[0]), .m0_wait(mwait[0]), .m0_rddata(mrd[0]),
    .m1_addr(maddr[1]), .m1_wrdata(mwd[1]), .m1_bytesel(mbe[1]), .m1_wren(mwr[1]),
    .m1_strobe(mstb[1]), .m1_lock(mlock[1]), .m1_wait(mwait[1]), .m1_rddata(mrd[1]),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_bytesel(s_bytesel), .s_wren(s_wren),
    .s_strobe(s_strobe), .s_wait(s_wait), .s_rddata(s_rddata), .grant(gnt)
  );

  int          total = 0;
  int          bad = 0;
  int          lat_mode = 0;
  int          exp_next = -1;
  bit          lk_pend = 0;
  bit          lk_m = 0;
  txn_t        q0[$];
  txn_t        q1[$];
  logic [31:0] sram[256];
  logic [31:0] ref_mem[256];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slave: per-transaction wait count, memory updated on write completion.
  initial begin
    int cnt = 0;
    int lat = 0;
    s_wait = 1'b0;
    s_rddata = '0;
    forever begin
      @(negedge clk);
      if (reset_n && s_strobe && !s_wait && s_wren)
        for (int b = 0; b < 4; b++)
          if (s_bytesel[b]) sram[s_addr[7:0]][8*b +: 8] = s_wrdata[8*b +: 8];
      if (reset_n && s_strobe && s_wait) cnt++;
      else cnt = 0;
      @(posedge clk);
      #2;
      if (cnt == 0) lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      s_wait = s_strobe && (cnt < lat);
      s_rddata = sram[s_addr[7:0]];
    end
  end

  task automatic on_done(input bit m);
    txn_t t;
    int   n;
    if (exp_next >= 0) chk("arb_order", 64'(m), 64'(exp_next));
    chk("grant_at_done", 64'(gnt), m ? 64'd2 : 64'd1);
    n = m ? q1.size() : q0.size();
    chk("pending_txn", 64'(n > 0), 64'd1);
    if (n > 0) begin
      if (m) t = q1.pop_front();
      else   t = q0.pop_front();
      chk("slave_cmd", 64'({s_addr, s_wrdata, s_bytesel, s_wren}),
          64'({t.addr, t.data, t.be, t.wr}));
      if (!t.wr) chk("rddata", 64'(mrd[m]), 64'(ref_mem[t.addr[7:0]]));
      else
        for (int b = 0; b < 4; b++)
          if (t.be[b]) ref_mem[t.addr[7:0]][8*b +: 8] = t.data[8*b +: 8];
      if (t.lk) begin
        lk_pend = 1'b1;
        lk_m = m;
        exp_next = -1;
      end else begin
        exp_next = mstb[!m] ? int'(!m) : -1;
      end
    end
  endtask

  task automatic mon_master(input bit m);
    if (mstb[m] && !gnt[m]) chk("nongrant_wait", 64'(mwait[m]), 64'd1);
    if (mstb[m] && !mwait[m]) on_done(m);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (lk_pend) begin
          lk_pend = 1'b0;
          if (mstb[lk_m]) exp_next = int'(lk_m);
        end
        mon_master(1'b0);
        mon_master(1'b1);
        if (gnt == 2'b00) chk("idle_strobe", 64'(s_strobe), 64'd0);
      end
    end
  end

  task automatic drive(input bit m, input logic [16:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic wr, input logic lk);
    txn_t t;
    t.addr = a; t.data = d; t.be = be; t.wr = wr; t.lk = lk;
    maddr[m] = a; mwd[m] = d; mbe[m] = be; mwr[m] = wr; mlock[m] = lk; mstb[m] = 1'b1;
    if (m) q1.push_back(t);
    else   q0.push_back(t);
  endtask

  // Returns at 1ns after the clock edge that follows the completion cycle.
  task automatic wait_done(input bit m, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mstb[m] && !mwait[m]) && n < 1000);
    if (n >= 1000) begin
      total++;
      bad++;
      $display("FAIL done_timeout m%0d: got no completion want completion", m);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    mstb = 2'b00;
    mlock = 2'b00;
    #1;
    chk("rst_grant", 64'(gnt), 64'd0);
    chk("rst_strobe", 64'(s_strobe), 64'd0);
    chk("rst_sbus", 64'({s_addr, s_wrdata, s_bytesel, s_wren}), 64'd0);
    q0.delete();
    q1.delete();
    exp_next = -1;
    lk_pend = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_master(input bit m);
    int n;
    for (int i = 0; i < 40; i++) begin
      int gap = $urandom_range(0, 3);
      if (gap > 0) begin
        mstb[m] = 1'b0;
        idle(gap);
      end
      drive(m, 17'($urandom_range(0, 31)), $urandom, 4'($urandom_range(1, 15)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
      wait_done(m, n);
    end
    mstb[m] = 1'b0;
  endtask

  initial begin
    int n;
    maddr = '0; mwd = '0; mbe = '0; mwr = '0; mstb = '0; mlock = '0;
    reset_n = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 32'h5A000000 | i;
      ref_mem[i] = 32'h5A000000 | i;
    end
    sram[16] = 32'hDEADBEEF;
    ref_mem[16] = 32'hDEADBEEF;

    // Single read with three wait cycles
    reset_dut();
    lat_mode = 3;
    drive(1'b0, 17'h00010, 32'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1_idle_strobe", 64'(s_strobe), 64'd0);
    chk("t1_idle_grant", 64'(gnt), 64'd0);
    chk("t1_req_wait", 64'(mwait[0]), 64'd1);
    @(negedge clk);
    chk("t1_strobe_rise", 64'(s_strobe), 64'd1);
    chk("t1_grant", 64'(gnt), 64'd1);
    chk("t1_s_addr", 64'(s_addr), 64'h10);
    chk("t1_wait_1", 64'(mwait[0]), 64'd1);
    repeat (2) begin
      @(negedge clk);
      chk("t1_wait_n", 64'(mwait[0]), 64'd1);
    end
    @(negedge clk);
    chk("t1_done_wait", 64'(mwait[0]), 64'd0);
    chk("t1_rddata", 64'(mrd[0]), 64'hDEADBEEF);
    chk("t1_done_grant", 64'(gnt), 64'd1);
    @(posedge clk);
    #1;
    mstb[0] = 1'b0;

    // Simultaneous requests after reset: m0 first, then m1 with no gap, then m0
    reset_dut();
    lat_mode = 1;
    drive(1'b0, 17'h50, 32'hA0A0A0A0, 4'hF, 1'b1, 1'b0);
    drive(1'b1, 17'h51, 32'hB1B1B1B1, 4'hF, 1'b1, 1'b0);
    @(negedge clk);
    chk("t2_idle_grant", 64'(gnt), 64'd0);
    @(negedge clk);
    chk("t2_first", 64'(gnt), 64'd1);
    wait_done(1'b0, n);
    drive(1'b0, 17'h50, 32'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    chk("t2_handover", 64'(gnt), 64'd2);
    chk("t2_no_gap", 64'(s_strobe), 64'd1);
    chk("t2_m0_stalled", 64'(mwait[0]), 64'd1);
    wait_done(1'b1, n);
    mstb[1] = 1'b0;
    @(negedge clk);
    chk("t2_back_to_m0", 64'(gnt), 64'd1);
    wait_done(1'b0, n);
    mstb[0] = 1'b0;
    idle(2);

    // m1 back-to-back writes with zero-wait slave
    lat_mode = 0;
    drive(1'b1, 17'h40, 32'h11223344, 4'hF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b1, n);
      chk(i == 0 ? "t3_first_latency" : "t3_no_bubble", 64'(n), i == 0 ? 64'd2 : 64'd1);
      chk("t3_grant_hold", 64'(gnt), 64'd2);
      if (i < 3) drive(1'b1, 17'(32'h41 + i), 32'h11223344, 4'hF, 1'b1, 1'b0);
      else mstb[1] = 1'b0;
    end
    idle(2);

    // m0 locks for three transactions while m1 waits
    lat_mode = 1;
    drive(1'b0, 17'h60, 32'h600D0001, 4'hF, 1'b1, 1'b1);
    drive(1'b1, 17'h61, 32'h0, 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wait_done(1'b0, n);
      if (i < 2) begin
        drive(1'b0, 17'(32'h62 + i), 32'h600D0002 + i, 4'hF, 1'b1, i == 0);
        #1;
        chk("t4_m1_held", 64'(mwait[1]), 64'd1);
        chk("t4_lock_grant", 64'(gnt), 64'd1);
      end else begin
        mstb[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk("t4_release", 64'(gnt), 64'd2);
    wait_done(1'b1, n);
    mstb[1] = 1'b0;
    idle(2);

    // No preemption of an in-flight write
    lat_mode = 4;
    drive(1'b0, 17'h33, 32'hCAFEF00D, 4'h3, 1'b1, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    drive(1'b1, 17'h70, 32'h77777777, 4'hF, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("t5_grant_held", 64'(gnt), 64'd1);
      chk("t5_s_addr", 64'(s_addr), 64'h33);
      chk("t5_s_wrdata", 64'(s_wrdata), 64'hCAFEF00D);
    end
    wait_done(1'b0, n);
    mstb[0] = 1'b0;
    wait_done(1'b1, n);
    mstb[1] = 1'b0;
    idle(2);

    // Randomized concurrent traffic
    lat_mode = -1;
    fork
      rand_master(1'b0);
      rand_master(1'b1);
    join
    idle(4);
    chk("drain_q0", 64'(q0.size()), 64'd0);
    chk("drain_q1", 64'(q1.size()), 64'd0);

    // Reset in the middle of an m1 transaction
    lat_mode = 5;
    drive(1'b1, 17'h07, 32'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_grant", 64'(gnt), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_strobe", 64'(s_strobe), 64'd0);
    chk("t6_async_grant", 64'(gnt), 64'd0);
    reset_dut();
    lat_mode = 1;
    drive(1'b0, 17'h08, 32'h0, 4'hF, 1'b0, 1'b0);
    drive(1'b1, 17'h09, 32'h0, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_m0_first", 64'(gnt), 64'd1);
    wait_done(1'b0, n);
    mstb[0] = 1'b0;
    wait_done(1'b1, n);
    mstb[1] = 1'b0;
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
